wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among NREQ writeback sources: 0 = ALU, 1 = load unit, 2 = multi-cycle MUL/DIV.
- Grants at most one source per cycle and registers the winner's address, enable and data towards the register file.
- Replaces the plain writeback pipeline register wherever more than one source can complete in the same cycle.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- CNT_W, 16, width of the saturating contention counter.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- i_hold  input  1  freezes arbitration (register-file debug access); no grants while high.
- i_req_valid  input  NREQ  per-requester write request.
- i_req_wra  input  NREQ*5  per-requester write address; requester k uses bits [5k+4:5k].
- i_req_wrd  input  NREQ*32  per-requester write data; requester k uses bits [32k+31:32k].
- o_req_ready  output  NREQ  one-hot grant, combinational, same cycle as the accepted valid.
- o_regWe  output  1  register-file write enable, registered.
- o_WRA  output  5  register-file write address, registered.
- o_WRD  output  32  register-file write data, registered.
- o_contention_cnt  output  CNT_W  cycles in which two or more requests were valid and i_hold was low; saturating.

Behaviour:
- Reset values (asynchronous, rstn low):
  - o_regWe = 0, o_WRA = 0, o_WRD = 0.
  - Round-robin pointer ptr = 0.
  - o_contention_cnt = 0.
  - o_req_ready = 0 while rstn is low, forced combinationally.
- Requester rules:
  - Once valid is raised it stays high, with stable wra/wrd, until the cycle its ready is high.
  - The transfer happens in the cycle where valid and ready are both high.
- Grant, combinational:
  - If i_hold = 1 or no valid is high: o_req_ready = 0.
  - Otherwise grant the first valid requester found scanning ptr, ptr+1, ... wrapping mod NREQ.
  - o_req_ready is always one-hot or zero.
- Pointer:
  - On a grant to k: ptr <= (k+1) mod NREQ.
  - With no grant, ptr is unchanged. i_hold does not move ptr.
- Output register, latency 1 cycle from grant:
  - On a grant to k: o_WRA <= wra_k, o_WRD <= wrd_k, and o_regWe <= 1 if wra_k != 0, else 0.
  - A write to r0 is accepted (ready = 1) but produces o_regWe = 0, with o_WRA/o_WRD still loaded.
  - With no grant: o_regWe <= 0; o_WRA and o_WRD hold their last values.
- Throughput: one write per cycle. Back-to-back grants from the same requester are allowed only if it is the sole valid requester.
- Contention counter:
  - Increments by 1 in each cycle where popcount(i_req_valid) >= 2 and i_hold = 0.
  - Saturates at 2^CNT_W - 1; it never wraps.
- Reset mid-operation: a pending request is neither granted nor lost. Requesters keep valid high, and arbitration resumes from ptr = 0 after rstn deasserts.

Optional Feature:
- WBARB_FIXED_PRIO_EN.
- Defined:
  - Grant goes to the lowest-index valid requester (ALU > load > MDU).
  - ptr is not implemented and does not affect grants.
  - All other behaviour is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then single request: valid[1] = 1, wra = 5'd7, wrd = 32'hDEADBEEF.
  - Same cycle: ready = 3'b010.
  - Next cycle: o_regWe = 1, o_WRA = 7, o_WRD = 32'hDEADBEEF.
  - Following idle cycle: o_regWe = 0.
- All three valid continuously, each held until granted, then re-raised with new data:
  - Grants cycle 001, 010, 100, 001, ...
  - o_contention_cnt increments once per cycle in which two or more are valid.
- Write to r0: valid[0] = 1, wra = 0, wrd = 32'h1234.
  - ready[0] = 1.
  - Next cycle: o_regWe = 0, o_WRA = 0, o_WRD = 32'h1234.
- i_hold = 1 for 3 cycles with valid = 3'b101:
  - ready = 0 and o_regWe = 0 throughout; counter unchanged; ptr unchanged.
  - After release: requester 0 is granted first (ptr = 0).
- rstn pulsed low mid-stream, with ptr = 2 and output holding wra = 9:
  - Outputs go to 0 immediately and ready = 0.
  - After release with valid = 3'b111: first grant is 001.
- Saturation, with CNT_W overridden to 4: keep valid = 3'b011 for 20 cycles -> o_contention_cnt stops at 15.
  - With WBARB_FIXED_PRIO_EN defined, the same stimulus grants 001 every cycle that requester 0 is valid.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Shares the register-file write port among NREQ writeback sources
//            (round-robin; fixed priority when WBARB_FIXED_PRIO_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int NREQ  = 3,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_hold,
  input  logic [NREQ-1:0]     i_req_valid,
  input  logic [NREQ*5-1:0]   i_req_wra,
  input  logic [NREQ*32-1:0]  i_req_wrd,
  output logic [NREQ-1:0]     o_req_ready,
  output logic                o_regWe,
  output logic [4:0]          o_WRA,
  output logic [31:0]         o_WRD,
  output logic [CNT_W-1:0]    o_contention_cnt
);

  localparam int c_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [4:0]         w_wra_arr [NREQ];
  logic [31:0]        w_wrd_arr [NREQ];
  logic [c_IDX_W-1:0] w_gidx;
  logic               w_found;
  logic               w_take;
  logic               w_contend;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_wra_arr[g] = i_req_wra[g*5 +: 5];
    assign w_wrd_arr[g] = i_req_wrd[g*32 +: 32];
  end

`ifdef WBARB_FIXED_PRIO_EN
  // Downward scan so the lowest-index valid requester is the last to win.
  always_comb begin
    w_gidx  = '0;
    w_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req_valid[c_IDX_W'(i)]) begin
        w_gidx  = c_IDX_W'(i);
        w_found = 1'b1;
      end
    end
  end
`else
  logic [c_IDX_W-1:0] r_ptr;
  logic [c_IDX_W:0]   w_sum;
  logic [c_IDX_W-1:0] w_idx;

  // Scan ptr, ptr+1, ... modulo NREQ; first valid wins.
  always_comb begin
    w_gidx  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_ptr} + (c_IDX_W+1)'(i);
      if (w_sum >= (c_IDX_W+1)'(NREQ)) begin
        w_sum = w_sum - (c_IDX_W+1)'(NREQ);
      end
      w_idx = w_sum[c_IDX_W-1:0];
      if (!w_found && i_req_valid[w_idx]) begin
        w_gidx  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (w_take) begin
      r_ptr <= (w_gidx == c_IDX_W'(NREQ - 1)) ? '0 : w_gidx + c_IDX_W'(1);
    end
  end
`endif

  // Ready is forced low during reset so no pending request is consumed.
  always_comb begin
    o_req_ready = '0;
    if (rstn && !i_hold && w_found) begin
      o_req_ready[w_gidx] = 1'b1;
    end
  end

  assign w_take    = |o_req_ready;
  assign w_contend = !i_hold && ($countones(i_req_valid) >= 2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_regWe <= 1'b0;
      o_WRA   <= '0;
      o_WRD   <= '0;
    end else if (w_take) begin
      o_WRA   <= w_wra_arr[w_gidx];
      o_WRD   <= w_wrd_arr[w_gidx];
      o_regWe <= |w_wra_arr[w_gidx];
    end else begin
      o_regWe <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_contention_cnt <= '0;
    end else if (w_contend && (o_contention_cnt != {CNT_W{1'b1}})) begin
      o_contention_cnt <= o_contention_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
